// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x-oversampled start/data/parity/stop recovery
// presented on a valid/ready interface with per-word error flags and sticky overrun.
module uart_rx_deframer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clki,
    input  logic                 rst,
    input  logic                 smp_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } state_t;

    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 1);

    logic                 rxd_m;
    logic                 rxd_s;
    state_t               state;
    logic [3:0]           cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;

    logic                 handshake;
    logic                 stop_sample;
    logic                 accept;
    logic                 drop;
    logic                 par_calc;

    // NOTE: synchronizer flops reset to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign handshake   = rx_valid & rx_ready;
    assign stop_sample = smp_tick && (state == STOP) && (cnt == 4'd15);
    assign accept      = stop_sample && (!rx_valid || handshake);
    assign drop        = stop_sample && !accept;
    assign par_calc    = (^shreg ^ rxd_s) ^ PAR_ODD;

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            bit_cnt    <= 3'd0;
            shreg      <= '0;
            par_err_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (smp_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state <= START;
                            cnt   <= 4'd0;
                        end
                    end
                    START: begin
                        // Mid start bit: a line already back high was only a glitch.
                        if (cnt == 4'd7) begin
                            cnt     <= 4'd0;
                            bit_cnt <= 3'd0;
                            state   <= rxd_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(DATA_BITS - 1))
                                state <= PAR_EN ? PAR : STOP;
                        end
                    end
                    PAR: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            par_err_q <= par_calc;
                            state     <= STOP;
                        end
                    end
                    STOP: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15)
                            state <= rxd_s ? IDLE : BREAK;
                    end
                    BREAK: begin
                        if (rxd_s)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            // A commit in the handshake cycle replaces the word instead of emptying the slot.
            if (accept) begin
                rx_data    <= shreg;
                frame_err  <= ~rxd_s;
                parity_err <= PAR_EN & par_err_q;
                rx_valid   <= 1'b1;
            end else if (handshake) begin
                rx_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (handshake)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: an 8N1 instance and an 8E1 instance
// fed from a bit-level line driver, with words scoreboarded at each handshake.
module tb_uart_rx_deframer;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } word_t;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       smp_tick;
    logic       rxd0;
    logic       rxd1;
    logic       rx_ready;

    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       frame_err0, frame_err1;
    logic       parity_err0, parity_err1;
    logic       overrun0, overrun1;

    word_t      exp0[$], got0[$], exp1[$], got1[$];
    int         errors = 0;
    int         checks = 0;

    uart_rx_deframer #(.DATA_BITS(8), .PARITY(0)) dut0 (
        .clki      (clk),
        .rst       (rst),
        .smp_tick  (smp_tick),
        .rxd       (rxd0),
        .rx_data   (rx_data0),
        .rx_valid  (rx_valid0),
        .rx_ready  (rx_ready),
        .frame_err (frame_err0),
        .parity_err(parity_err0),
        .overrun   (overrun0)
    );

    uart_rx_deframer #(.DATA_BITS(8), .PARITY(2)) dut1 (
        .clki      (clk),
        .rst       (rst),
        .smp_tick  (smp_tick),
        .rxd       (rxd1),
        .rx_data   (rx_data1),
        .rx_valid  (rx_valid1),
        .rx_ready  (rx_ready),
        .frame_err (frame_err1),
        .parity_err(parity_err1),
        .overrun   (overrun1)
    );

    initial forever #5 clk = ~clk;

    // One tick every 4 clocks, driven on the falling edge.
    initial begin
        logic [1:0] div;
        div      = 2'd0;
        smp_tick = 1'b0;
        forever begin
            @(negedge clk);
            div      = div + 2'd1;
            smp_tick = (div == 2'd3);
        end
    end

    // Capture every handshake late in the low phase, after inputs have settled.
    initial forever begin
        @(negedge clk);
        #3;
        if (rx_valid0 && rx_ready) got0.push_back({rx_data0, frame_err0, parity_err0});
        if (rx_valid1 && rx_ready) got1.push_back({rx_data1, frame_err1, parity_err1});
    end

    task automatic bit_out(input bit which, input logic v, input int clks);
        if (which) rxd1 = v;
        else       rxd0 = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] data, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        bit_out(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) bit_out(which, data[i], BIT_CLKS);
        if (par_en) bit_out(which, par_bit, BIT_CLKS);
        bit_out(which, stop_bit, BIT_CLKS);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rx_data0, rx_valid0, frame_err0, parity_err0, overrun0} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut0 got=%h exp=000", {rx_data0, rx_valid0, frame_err0, parity_err0, overrun0});
        end
        checks++;
        if ({rx_data1, rx_valid1, frame_err1, parity_err1, overrun1} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut1 got=%h exp=000", {rx_data1, rx_valid1, frame_err1, parity_err1, overrun1});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if ({rx_valid0, rx_valid1, overrun0, overrun1} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=0000", {rx_valid0, rx_valid1, overrun0, overrun1});
        end
    endtask

    task automatic test_basic;
        exp0.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (got0.size() !== 1) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=1", got0.size());
        end else begin
            word_t g, e;
            g = got0.pop_front();
            e = exp0.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic_word got=%h/%b/%b exp=%h/%b/%b", g.data, g.ferr, g.perr, e.data, e.ferr, e.perr);
            end
        end
        checks++;
        if ({rx_valid0, overrun0} !== 2'b00) begin
            errors++;
            $display("FAIL basic_after got valid/ovr=%b exp=00", {rx_valid0, overrun0});
        end
        exp0.delete();
        got0.delete();
    endtask

    task automatic test_glitch;
        bit_out(0, 1'b0, 12);
        bit_out(0, 1'b1, 160);
        #1;
        checks++;
        if (rx_valid0 !== 1'b0 || got0.size() !== 0) begin
            errors++;
            $display("FAIL glitch_reject got valid=%b words=%0d exp valid=0 words=0", rx_valid0, got0.size());
        end
        exp0.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (got0.size() !== 1) begin
            errors++;
            $display("FAIL glitch_next_count got=%0d exp=1", got0.size());
        end else begin
            word_t g, e;
            g = got0.pop_front();
            e = exp0.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL glitch_next_word got=%h/%b/%b exp=%h/%b/%b", g.data, g.ferr, g.perr, e.data, e.ferr, e.perr);
            end
        end
        exp0.delete();
        got0.delete();
    endtask

    task automatic test_break;
        exp0.push_back({8'h3C, 1'b1, 1'b0});
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        bit_out(0, 1'b0, 40 * 4);
        bit_out(0, 1'b1, 80);
        checks++;
        if (got0.size() !== 1) begin
            errors++;
            $display("FAIL break_count got=%0d exp=1", got0.size());
        end else begin
            word_t g, e;
            g = got0.pop_front();
            e = exp0.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL break_word got=%h/%b/%b exp=%h/%b/%b", g.data, g.ferr, g.perr, e.data, e.ferr, e.perr);
            end
        end
        exp0.delete();
        got0.delete();
        exp0.push_back({8'hC3, 1'b0, 1'b0});
        send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (got0.size() !== 1) begin
            errors++;
            $display("FAIL break_next_count got=%0d exp=1", got0.size());
        end else begin
            word_t g, e;
            g = got0.pop_front();
            e = exp0.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL break_next_word got=%h/%b/%b exp=%h/%b/%b", g.data, g.ferr, g.perr, e.data, e.ferr, e.perr);
            end
        end
        exp0.delete();
        got0.delete();
    endtask

    task automatic test_parity;
        logic [7:0] d;
        logic       pb;
        d = 8'h07;
        for (int k = 0; k < 2; k++) begin
            pb = k[0];
            // Even parity: error when data XOR plus the parity bit is odd.
            exp1.push_back({d, 1'b0, (^d) ^ pb});
            send_frame(1, d, 1, pb, 1'b1);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (got1.size() !== 2) begin
            errors++;
            $display("FAIL parity_count got=%0d exp=2", got1.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                word_t g, e;
                g = got1.pop_front();
                e = exp1.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL parity_word%0d got=%h/%b/%b exp=%h/%b/%b", k, g.data, g.ferr, g.perr, e.data, e.ferr, e.perr);
                end
            end
        end
        exp1.delete();
        got1.delete();
    endtask

    task automatic test_overrun;
        rx_ready = 1'b0;
        exp0.push_back({8'h11, 1'b0, 1'b0});
        send_frame(0, 8'h11, 0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if ({rx_valid0, rx_data0, overrun0} !== {1'b1, 8'h11, 1'b1}) begin
            errors++;
            $display("FAIL overrun_hold got valid=%b data=%h ovr=%b exp valid=1 data=11 ovr=1", rx_valid0, rx_data0, overrun0);
        end
        @(negedge clk);
        rx_ready = 1'b1;
        #1;
        checks++;
        if (overrun0 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_before_edge got=%b exp=1", overrun0);
        end
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        checks++;
        if ({rx_valid0, overrun0} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clear got valid/ovr=%b exp=00", {rx_valid0, overrun0});
        end
        checks++;
        if (got0.size() !== 1) begin
            errors++;
            $display("FAIL overrun_count got=%0d exp=1", got0.size());
        end else begin
            word_t g, e;
            g = got0.pop_front();
            e = exp0.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL overrun_word got=%h/%b/%b exp=%h/%b/%b", g.data, g.ferr, g.perr, e.data, e.ferr, e.perr);
            end
        end
        rx_ready = 1'b1;
        exp0.delete();
        got0.delete();
    endtask

    task automatic test_midframe_reset;
        logic [7:0] d;
        d = 8'h5A;
        rx_ready = 1'b0;
        send_frame(0, 8'h96, 0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if ({rx_valid0, rx_data0} !== {1'b1, 8'h96}) begin
            errors++;
            $display("FAIL prereset_hold got valid=%b data=%h exp valid=1 data=96", rx_valid0, rx_data0);
        end
        bit_out(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) bit_out(0, d[i], BIT_CLKS);
        bit_out(0, d[4], BIT_CLKS / 2);
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_data0, rx_valid0, frame_err0, parity_err0, overrun0} !== 12'h0) begin
            errors++;
            $display("FAIL midframe_reset got=%h exp=000", {rx_data0, rx_valid0, frame_err0, parity_err0, overrun0});
        end
        rxd0 = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        rx_ready = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        checks++;
        if (rx_valid0 !== 1'b0 || got0.size() !== 0) begin
            errors++;
            $display("FAIL postreset_quiet got valid=%b words=%0d exp valid=0 words=0", rx_valid0, got0.size());
        end
        exp0.push_back({d, 1'b0, 1'b0});
        send_frame(0, d, 0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (got0.size() !== 1) begin
            errors++;
            $display("FAIL postreset_count got=%0d exp=1", got0.size());
        end else begin
            word_t g, e;
            g = got0.pop_front();
            e = exp0.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL postreset_word got=%h/%b/%b exp=%h/%b/%b", g.data, g.ferr, g.perr, e.data, e.ferr, e.perr);
            end
        end
        exp0.delete();
        got0.delete();
    endtask

    initial begin
        rst      = 1'b1;
        rxd0     = 1'b1;
        rxd1     = 1'b1;
        rx_ready = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_parity();
        test_overrun();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
